dual_port_ram_be: RTL and testbench
===================================

Name: dual_port_ram_be

Overview:
Parametrised true dual-port synchronous RAM for the packet simulator memory subsystem. It is the successor to the basic two-port word RAM and adds:
- per-byte write enables
- selectable read latency
- selectable read-during-write semantics
- deterministic write-collision resolution
- a hardware initialisation sequencer that fills the array after every reset
Both ports serve the core and the DMA/NoC interface in the same clock domain.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DEPTH, 1024, number of words; must be ≥ 2.
ADDR_WIDTH, $clog2(DEPTH), address width.
READ_LATENCY, 1, cycles from accepted read to data/valid; legal values 1 or 2.
RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first).
INIT_PATTERN, 1, fill value: 0 = all zeros, 1 = word j holds DEPTH-j.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
a_enable_in  in  1  port A access request.
a_wb_in  in  1  port A write (1) / read (0).
a_be_in  in  DATA_WIDTH/8  port A byte enables; bit k covers bits [8k+7:8k].
a_addr_in  in  ADDR_WIDTH  port A word address.
a_data_in  in  DATA_WIDTH  port A write data.
a_data_out  out  DATA_WIDTH  port A read data.
a_valid_out  out  1  port A read data valid, one-cycle pulse.
b_* (enable_in, wb_in, be_in, addr_in, data_in, data_out, valid_out): identical set for port B.
ready_out  out  1  high when initialisation is complete and requests are accepted.
collision_out  out  1  one-cycle pulse for a same-address write/write collision.

Behaviour:
- Clock and reset: one clock (clock). reset is asynchronous and active-high.
- Reset values: all *_data_out = 0, *_valid_out = 0, ready_out = 0, collision_out = 0, FSM = INIT, init counter = 0, latency pipeline cleared. Array contents are not reset directly; the INIT sequence overwrites them.
- FSM states: INIT, READY.
  - INIT: writes one word per cycle at the counter address with INIT_PATTERN value, then increments the counter.
  - The first init write occurs on the first rising edge after reset deasserts.
  - After word DEPTH-1 is written, the FSM moves to READY; ready_out is registered high on that same edge. Init therefore takes exactly DEPTH cycles.
  - READY is terminal until reset.
- Requests during INIT: all port requests are ignored; no write, no valid pulse, no collision.
- Reset asserted mid-INIT or mid-READY: immediate return to INIT with counter 0. After deassertion the full fill restarts. In-flight reads are discarded and produce no valid pulse.
- Accepted access: enable_in && ready_out, sampled at the rising edge.
- Write (wb_in = 1): only bytes with be_in[k] = 1 are updated; be_in = 0 makes the write a no-op. A write produces no valid pulse, and data_out holds its previous value.
- Read (wb_in = 0): be_in is ignored.
  - READ_LATENCY = 1: data_out and valid_out are registered on the accepting edge.
  - READ_LATENCY = 2: an extra output register stage; data and valid appear one edge later.
  - Back-to-back reads are fully pipelined, one per cycle per port.
  - data_out holds its last value when valid_out is low.
- Read-during-write (same address, same cycle, same port or the other port):
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the word with the effective byte writes merged in.
- Write/write collision: both ports write the same address in the same cycle.
  - Port A wins for each byte enabled on A.
  - Bytes enabled only on B are taken from B.
  - collision_out pulses high for one cycle, registered on the same edge as the write.
  - No collision is flagged if the byte-enable masks are disjoint.
- Addresses ≥ DEPTH (only possible when DEPTH is not a power of 2):
  - Writes are dropped.
  - Reads return 0 with a normal valid pulse.

Test Plan:
1. DEPTH=16, INIT_PATTERN=1: deassert reset, hold both enables high -> ready_out rises exactly 16 cycles after deassertion, no valid pulses before that; reading addr 0..15 returns 16..1.
2. READ_LATENCY=2: A writes 0xDEADBEEF to addr 3 with be=4'b1111, then reads addr 3 -> a_valid_out pulses exactly 2 cycles after the read edge, a_data_out = 0xDEADBEEF; b_valid_out stays 0.
3. Byte enables: addr 5 holds 0x11223344; A writes 0xAABBCCDD with be=4'b0101 -> a subsequent read returns 0x11BB33DD.
4. Collision: same cycle, A writes 0xAAAAAAAA with be=4'b0011 and B writes 0xBBBBBBBB with be=4'b1111 to addr 7 -> addr 7 = 0xBBBBAAAA and collision_out pulses once. With A be=4'b0011 and B be=4'b1100 -> same data, collision_out stays 0.
5. RDW: addr 2 = 0x1; A writes 0x5 to addr 2 while B reads addr 2 -> b_data_out = 0x1 when RDW_MODE=0, 0x5 when RDW_MODE=1.
6. Reset mid-operation: assert reset during a pending READ_LATENCY=2 read, and again at init word 8 -> no valid pulse appears, ready_out drops immediately, and a fresh full 16-cycle fill runs.

Source files
------------

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port synchronous RAM with per-byte write
// enables, 1- or 2-cycle read latency, selectable read-during-write result,
// port-A-priority write collision merge and a post-reset fill sequencer.
module dual_port_ram_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int INIT_PATTERN = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_enable_in,
    input  logic                    a_wb_in,
    input  logic [DATA_WIDTH/8-1:0] a_be_in,
    input  logic [ADDR_WIDTH-1:0]   a_addr_in,
    input  logic [DATA_WIDTH-1:0]   a_data_in,
    output logic [DATA_WIDTH-1:0]   a_data_out,
    output logic                    a_valid_out,
    input  logic                    b_enable_in,
    input  logic                    b_wb_in,
    input  logic [DATA_WIDTH/8-1:0] b_be_in,
    input  logic [ADDR_WIDTH-1:0]   b_addr_in,
    input  logic [DATA_WIDTH-1:0]   b_data_in,
    output logic [DATA_WIDTH-1:0]   b_data_out,
    output logic                    b_valid_out,
    output logic                    ready_out,
    output logic                    collision_out
);

    localparam int                    BE_W       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] DEPTH_WORD = DATA_WIDTH'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD  = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Word value at addr after this cycle's writes: B applied first so that
    // A wins every byte it enables, B supplies the bytes only it enables.
    function automatic logic [DATA_WIDTH-1:0] post_write(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic                  a_we,
        input logic [ADDR_WIDTH-1:0] a_addr,
        input logic [DATA_WIDTH-1:0] a_data,
        input logic [BE_W-1:0]       a_be,
        input logic                  b_we,
        input logic [ADDR_WIDTH-1:0] b_addr,
        input logic [DATA_WIDTH-1:0] b_data,
        input logic [BE_W-1:0]       b_be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        if (b_we && (b_addr == addr)) begin
            res = merge_bytes(res, b_data, b_be);
        end else begin
            res = res;
        end
        if (a_we && (a_addr == addr)) begin
            res = merge_bytes(res, a_data, a_be);
        end else begin
            res = res;
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  collision_q, collision_d;
    logic [DATA_WIDTH-1:0] a_rd1_data_q, a_rd1_data_d;
    logic [DATA_WIDTH-1:0] b_rd1_data_q, b_rd1_data_d;
    logic                  a_rd1_vld_q, a_rd1_vld_d;
    logic                  b_rd1_vld_q, b_rd1_vld_d;

    logic                  init_we_s;
    logic [DATA_WIDTH-1:0] init_word_s;
    logic                  a_in_range_s, b_in_range_s;
    logic                  a_we_s, b_we_s, a_rd_s, b_rd_s;
    logic [DATA_WIDTH-1:0] a_old_s, b_old_s;
    logic [DATA_WIDTH-1:0] a_new_s, b_new_s;
    logic [DATA_WIDTH-1:0] a_rd_word_s, b_rd_word_s;

    // Init/ready sequencer: one fill write per cycle until the last word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        init_we_s   = 1'b0;
        init_word_s = ZERO_WORD;
        case (state_q)
            ST_INIT: begin
                init_we_s = 1'b1;
                if (INIT_PATTERN == 1) begin
                    init_word_s = DEPTH_WORD - DATA_WIDTH'(cnt_q);
                end else begin
                    init_word_s = ZERO_WORD;
                end
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {ADDR_WIDTH{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // Request decode, write merge, read-during-write selection, collision.
    always_comb begin
        a_in_range_s = ({1'b0, a_addr_in} < DEPTH_EXT);
        b_in_range_s = ({1'b0, b_addr_in} < DEPTH_EXT);
        a_we_s = a_enable_in && ready_q && a_wb_in && a_in_range_s;
        b_we_s = b_enable_in && ready_q && b_wb_in && b_in_range_s;
        a_rd_s = a_enable_in && ready_q && !a_wb_in;
        b_rd_s = b_enable_in && ready_q && !b_wb_in;

        if (a_in_range_s) begin
            a_old_s = mem_q[a_addr_in];
        end else begin
            a_old_s = ZERO_WORD;
        end
        if (b_in_range_s) begin
            b_old_s = mem_q[b_addr_in];
        end else begin
            b_old_s = ZERO_WORD;
        end

        a_new_s = post_write(a_addr_in, a_old_s, a_we_s, a_addr_in, a_data_in, a_be_in,
                             b_we_s, b_addr_in, b_data_in, b_be_in);
        b_new_s = post_write(b_addr_in, b_old_s, a_we_s, a_addr_in, a_data_in, a_be_in,
                             b_we_s, b_addr_in, b_data_in, b_be_in);

        // Out-of-range reads see a_old_s = 0 and no write can match them.
        if (RDW_MODE == 1) begin
            a_rd_word_s = a_in_range_s ? a_new_s : ZERO_WORD;
            b_rd_word_s = b_in_range_s ? b_new_s : ZERO_WORD;
        end else begin
            a_rd_word_s = a_old_s;
            b_rd_word_s = b_old_s;
        end

        a_rd1_vld_d  = a_rd_s;
        b_rd1_vld_d  = b_rd_s;
        a_rd1_data_d = a_rd_s ? a_rd_word_s : a_rd1_data_q;
        b_rd1_data_d = b_rd_s ? b_rd_word_s : b_rd1_data_q;

        collision_d = a_we_s && b_we_s && (a_addr_in == b_addr_in) &&
                      ((a_be_in & b_be_in) != {BE_W{1'b0}});
    end

    // Control state, first read stage and collision flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= {ADDR_WIDTH{1'b0}};
            ready_q      <= 1'b0;
            collision_q  <= 1'b0;
            a_rd1_vld_q  <= 1'b0;
            b_rd1_vld_q  <= 1'b0;
            a_rd1_data_q <= ZERO_WORD;
            b_rd1_data_q <= ZERO_WORD;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            collision_q  <= collision_d;
            a_rd1_vld_q  <= a_rd1_vld_d;
            b_rd1_vld_q  <= b_rd1_vld_d;
            a_rd1_data_q <= a_rd1_data_d;
            b_rd1_data_q <= b_rd1_data_d;
        end
    end

    // Storage array: fill words during init, merged port writes afterwards.
    always_ff @(posedge clock) begin
        if (init_we_s) begin
            mem_q[cnt_q] <= init_word_s;
        end else begin
            if (a_we_s) begin
                mem_q[a_addr_in] <= a_new_s;
            end
            if (b_we_s) begin
                mem_q[b_addr_in] <= b_new_s;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] a_rd2_data_q, b_rd2_data_q;
            logic                  a_rd2_vld_q, b_rd2_vld_q;

            // Extra output stage; data only advances with a valid read.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_rd2_vld_q  <= 1'b0;
                    b_rd2_vld_q  <= 1'b0;
                    a_rd2_data_q <= ZERO_WORD;
                    b_rd2_data_q <= ZERO_WORD;
                end else begin
                    a_rd2_vld_q  <= a_rd1_vld_q;
                    b_rd2_vld_q  <= b_rd1_vld_q;
                    a_rd2_data_q <= a_rd1_vld_q ? a_rd1_data_q : a_rd2_data_q;
                    b_rd2_data_q <= b_rd1_vld_q ? b_rd1_data_q : b_rd2_data_q;
                end
            end

            assign a_data_out  = a_rd2_data_q;
            assign a_valid_out = a_rd2_vld_q;
            assign b_data_out  = b_rd2_data_q;
            assign b_valid_out = b_rd2_vld_q;
        end else begin : g_lat1
            assign a_data_out  = a_rd1_data_q;
            assign a_valid_out = a_rd1_vld_q;
            assign b_data_out  = b_rd1_data_q;
            assign b_valid_out = b_rd1_vld_q;
        end
    endgenerate

    assign ready_out     = ready_q;
    assign collision_out = collision_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances share stimulus.
// u_dut0: DEPTH 16, 2-cycle latency, old-data RDW.
// u_dut1: DEPTH 12 (addresses 12..15 out of range), 1-cycle latency, new-data RDW.
module tb_dual_port_ram_be;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_en = 1'b0, a_wb = 1'b0, b_en = 1'b0, b_wb = 1'b0;
    logic [3:0]  a_be = 4'h0, b_be = 4'h0, a_addr = 4'h0, b_addr = 4'h0;
    logic [31:0] a_din = 32'h0, b_din = 32'h0;

    logic [31:0] a_do0, b_do0, a_do1, b_do1;
    logic        a_v0, b_v0, rdy0, col0, a_v1, b_v1, rdy1, col1;

    int          vec_cnt = 0;
    int          miscompares = 0;
    logic [31:0] last0 = 32'h0, last1 = 32'h0;

    typedef struct {
        logic        wb;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vt [15];

    always #5 clock = ~clock;

    dual_port_ram_be #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2),
                       .RDW_MODE(0), .INIT_PATTERN(1)) u_dut0 (
        .clock(clock), .reset(reset),
        .a_enable_in(a_en), .a_wb_in(a_wb), .a_be_in(a_be), .a_addr_in(a_addr),
        .a_data_in(a_din), .a_data_out(a_do0), .a_valid_out(a_v0),
        .b_enable_in(b_en), .b_wb_in(b_wb), .b_be_in(b_be), .b_addr_in(b_addr),
        .b_data_in(b_din), .b_data_out(b_do0), .b_valid_out(b_v0),
        .ready_out(rdy0), .collision_out(col0));

    dual_port_ram_be #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4), .READ_LATENCY(1),
                       .RDW_MODE(1), .INIT_PATTERN(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .a_enable_in(a_en), .a_wb_in(a_wb), .a_be_in(a_be), .a_addr_in(a_addr),
        .a_data_in(a_din), .a_data_out(a_do1), .a_valid_out(a_v1),
        .b_enable_in(b_en), .b_wb_in(b_wb), .b_be_in(b_be), .b_addr_in(b_addr),
        .b_data_in(b_din), .b_data_out(b_do1), .b_valid_out(b_v1),
        .ready_out(rdy1), .collision_out(col1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        a_en = 1'b0;
        b_en = 1'b0;
        repeat (n) @(posedge clock);
    endtask

    // Release reset with both ports reading addr and check the fill timing.
    task automatic fill(input logic [3:0] addr, input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b0; a_addr = addr;
        b_en = 1'b1; b_wb = 1'b0; b_addr = addr;
        reset = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            @(posedge clock); #1;
            chk("fill_rdy0", {31'h0, rdy0}, {31'h0, (n >= 16)});
            chk("fill_rdy1", {31'h0, rdy1}, {31'h0, (n >= 12)});
            chk("fill_av0", {31'h0, a_v0}, {31'h0, (n >= 18)});
            chk("fill_bv0", {31'h0, b_v0}, {31'h0, (n >= 18)});
            chk("fill_av1", {31'h0, a_v1}, {31'h0, (n >= 13)});
            chk("fill_bv1", {31'h0, b_v1}, {31'h0, (n >= 13)});
            chk("fill_ad1", a_do1, (n >= 13) ? e1 : 32'h0);
            chk("fill_ad0", a_do0, (n >= 18) ? e0 : 32'h0);
        end
        idle(2);
        last0 = e0;
        last1 = e1;
    endtask

    task automatic rd_a(input logic [3:0] addr, input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b0; a_addr = addr; a_be = 4'h0; b_en = 1'b0;
        @(posedge clock); #1;
        chk("rd_v1", {31'h0, a_v1}, 32'h1);
        chk("rd_d1", a_do1, e1);
        chk("rd_v0_early", {31'h0, a_v0}, 32'h0);
        @(negedge clock);
        a_en = 1'b0;
        @(posedge clock); #1;
        chk("rd_v0", {31'h0, a_v0}, 32'h1);
        chk("rd_d0", a_do0, e0);
        chk("rd_v1_drop", {31'h0, a_v1}, 32'h0);
        chk("rd_bv", {30'h0, b_v0, b_v1}, 32'h0);
        last0 = e0;
        last1 = e1;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b1; a_addr = addr; a_din = d; a_be = be; b_en = 1'b0;
        @(posedge clock); #1;
        chk("wr_v1", {31'h0, a_v1}, 32'h0);
        chk("wr_hold1", a_do1, last1);
        @(negedge clock);
        a_en = 1'b0; a_wb = 1'b0;
        @(posedge clock); #1;
        chk("wr_v0", {31'h0, a_v0}, 32'h0);
        chk("wr_hold0", a_do0, last0);
        chk("wr_col", {30'h0, col0, col1}, 32'h0);
    endtask

    initial begin
        logic [31:0] p0 [3];
        logic [31:0] p1 [3];

        vt[0]  = '{1'b0, 4'h0, 4'd0,  32'h0,        32'd16,       32'd12};
        vt[1]  = '{1'b0, 4'h0, 4'd15, 32'h0,        32'd1,        32'd0};
        vt[2]  = '{1'b0, 4'h0, 4'd11, 32'h0,        32'd5,        32'd1};
        vt[3]  = '{1'b0, 4'h0, 4'd5,  32'h0,        32'd11,       32'd7};
        vt[4]  = '{1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 32'h0,        32'h0};
        vt[5]  = '{1'b0, 4'h0, 4'd3,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vt[6]  = '{1'b1, 4'hF, 4'd5,  32'h11223344, 32'h0,        32'h0};
        vt[7]  = '{1'b1, 4'h5, 4'd5,  32'hAABBCCDD, 32'h0,        32'h0};
        vt[8]  = '{1'b0, 4'h0, 4'd5,  32'h0,        32'h11BB33DD, 32'h11BB33DD};
        vt[9]  = '{1'b1, 4'h0, 4'd6,  32'hCAFEF00D, 32'h0,        32'h0};
        vt[10] = '{1'b0, 4'h0, 4'd6,  32'h0,        32'd10,       32'd6};
        vt[11] = '{1'b1, 4'hF, 4'd14, 32'h12345678, 32'h0,        32'h0};
        vt[12] = '{1'b0, 4'h0, 4'd14, 32'h0,        32'h12345678, 32'h0};
        vt[13] = '{1'b1, 4'h8, 4'd3,  32'h5A000000, 32'h0,        32'h0};
        vt[14] = '{1'b0, 4'h0, 4'd3,  32'h0,        32'h5AADBEEF, 32'h5AADBEEF};
        p0[0] = 32'd7; p0[1] = 32'd6; p0[2] = 32'd5;
        p1[0] = 32'd3; p1[1] = 32'd2; p1[2] = 32'd1;

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rdy", {30'h0, rdy0, rdy1}, 32'h0);
        chk("rst_col", {30'h0, col0, col1}, 32'h0);
        chk("rst_vld", {28'h0, a_v0, b_v0, a_v1, b_v1}, 32'h0);
        chk("rst_ad0", a_do0, 32'h0);
        chk("rst_bd1", b_do1, 32'h0);

        // Initial fill with both ports requesting reads of addr 0.
        fill(4'd0, 32'd16, 32'd12);

        // Directed single-op vectors on port A.
        for (int i = 0; i < 15; i++) begin
            if (vt[i].wb) begin
                wr_a(vt[i].addr, vt[i].data, vt[i].be);
            end else begin
                rd_a(vt[i].addr, vt[i].e0, vt[i].e1);
            end
        end

        // Back-to-back pipelined reads of addrs 9, 10, 11.
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b0; a_addr = 4'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("pipe_v1", {31'h0, a_v1}, {31'h0, (i < 3)});
            if (i < 3) chk("pipe_d1", a_do1, p1[i]);
            chk("pipe_v0", {31'h0, a_v0}, {31'h0, (i >= 1 && i < 4)});
            if (i >= 1 && i < 4) chk("pipe_d0", a_do0, p0[i-1]);
            @(negedge clock);
            if (i == 0) a_addr = 4'd10;
            else if (i == 1) a_addr = 4'd11;
            else a_en = 1'b0;
        end
        last0 = 32'd5;
        last1 = 32'd1;

        // Overlapping write/write collision at addr 7.
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b1; a_addr = 4'd7; a_din = 32'hAAAAAAAA; a_be = 4'h3;
        b_en = 1'b1; b_wb = 1'b1; b_addr = 4'd7; b_din = 32'hBBBBBBBB; b_be = 4'hF;
        @(posedge clock); #1;
        chk("col_pulse", {30'h0, col0, col1}, 32'h3);
        @(negedge clock);
        a_en = 1'b0; b_en = 1'b0; a_wb = 1'b0; b_wb = 1'b0;
        @(posedge clock); #1;
        chk("col_drop", {30'h0, col0, col1}, 32'h0);
        rd_a(4'd7, 32'hBBBBAAAA, 32'hBBBBAAAA);

        // Disjoint byte masks to the same addr 8: merged, no collision.
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b1; a_addr = 4'd8; a_din = 32'hAAAAAAAA; a_be = 4'h3;
        b_en = 1'b1; b_wb = 1'b1; b_addr = 4'd8; b_din = 32'hBBBBBBBB; b_be = 4'hC;
        @(posedge clock); #1;
        chk("nocol", {30'h0, col0, col1}, 32'h0);
        @(negedge clock);
        a_en = 1'b0; b_en = 1'b0; a_wb = 1'b0; b_wb = 1'b0;
        rd_a(4'd8, 32'hBBBBAAAA, 32'hBBBBAAAA);

        // Read-during-write across ports at addr 2.
        wr_a(4'd2, 32'h1, 4'hF);
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b1; a_addr = 4'd2; a_din = 32'h5; a_be = 4'hF;
        b_en = 1'b1; b_wb = 1'b0; b_addr = 4'd2;
        @(posedge clock); #1;
        chk("rdw_bv1", {31'h0, b_v1}, 32'h1);
        chk("rdw_new", b_do1, 32'h5);
        @(negedge clock);
        a_en = 1'b0; b_en = 1'b0; a_wb = 1'b0;
        @(posedge clock); #1;
        chk("rdw_bv0", {31'h0, b_v0}, 32'h1);
        chk("rdw_old", b_do0, 32'h1);
        rd_a(4'd2, 32'h5, 32'h5);

        // Reset while a 2-cycle read is pending.
        @(negedge clock);
        a_en = 1'b1; a_wb = 1'b0; a_addr = 4'd0;
        @(posedge clock); #1;
        @(negedge clock);
        a_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_rdy_drop", {30'h0, rdy0, rdy1}, 32'h0);
        chk("rst_vld_drop", {30'h0, a_v0, a_v1}, 32'h0);
        @(posedge clock); #1;
        chk("rst_no_late_v0", {31'h0, a_v0}, 32'h0);

        // Reset again at init word 8.
        @(negedge clock);
        reset = 1'b0;
        a_en = 1'b1; a_wb = 1'b0; a_addr = 4'd4;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clock); #1;
            chk("mid_rdy", {30'h0, rdy0, rdy1}, 32'h0);
            chk("mid_vld", {30'h0, a_v0, a_v1}, 32'h0);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", {30'h0, rdy0, rdy1}, 32'h0);
        fill(4'd4, 32'd12, 32'd8);

        // Contents were refilled, earlier writes are gone.
        rd_a(4'd3, 32'd13, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
